// File: rtl/ling8_stream_acc.sv
// ---------------------------------------------------------------------------
// ling8_stream_acc
//
// Streaming 8-bit packet accumulator. Bytes arrive on a valid/ready stream
// and are grouped into packets by in_last. Each accepted byte is added to
// the running accumulator through the combinational Ling adder
// P8_node_adder. When the last beat of a packet is accepted, the packet
// sum (mod 256), beat count, wrap count and a sticky saturation flag are
// loaded into an output register that has its own valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready
//   in_data    byte to add
//   in_last    beat closes the current packet
//   out_valid  packet result valid
//   out_ready  downstream accepts the result
//   out_sum    packet sum modulo 256
//   out_count  beats in packet, saturating at 2^CNT_W-1
//   out_wraps  mod-256 wrap-arounds in packet, saturating at 2^CNT_W-1
//   out_sat    a counter tried to step past its maximum during the packet
//
// The file also holds P8_node_adder, the 8-bit sparse-4 Ling adder.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// P8_node_adder
//
// Combinational 8-bit adder, no carry-in and no carry-out.
// The lower nibble uses Ling pseudo-carries h_i (c_i = t_{i-1} & h_i); the
// only long carry is the pseudo-carry into bit 4 (the sparse-4 node). The
// upper nibble is computed for both carry-in values and selected by c4.
//
// Ports:
//   a, b   8-bit operands
//   sum    a + b modulo 256
// ---------------------------------------------------------------------------
module P8_node_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

    logic [7:0] g;
    logic [7:0] t;
    logic [7:0] p;
    logic       h1, h2, h3, h4;
    logic       c1, c2, c3, c4;
    logic [3:0] hi_sum0;
    logic [3:0] hi_sum1;

    // Ripple sum of one nibble for a known carry-in; used for both
    // speculative upper-nibble results.
    function automatic logic [3:0] nibble_sum(
        input logic [3:0] gn,
        input logic [3:0] tn,
        input logic [3:0] pn,
        input logic       cin
    );
        logic       c;
        logic [3:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = pn[i] ^ c;
            c    = gn[i] | (tn[i] & c);
        end
        return s;
    endfunction

    assign g = a & b;
    assign t = a | b;
    assign p = a ^ b;

    // Ling pseudo-carries of the lower nibble: h4 needs no t3 term, which
    // is what shortens the critical path relative to a true carry.
    assign h1 = g[0];
    assign h2 = g[1] | g[0];
    assign h3 = g[2] | g[1] | (t[1] & g[0]);
    assign h4 = g[3] | g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0]);

    // Real carries are recovered by folding in the propagate bit below.
    assign c1 = t[0] & h1;
    assign c2 = t[1] & h2;
    assign c3 = t[2] & h3;
    assign c4 = t[3] & h4;

    assign hi_sum0 = nibble_sum(g[7:4], t[7:4], p[7:4], 1'b0);
    assign hi_sum1 = nibble_sum(g[7:4], t[7:4], p[7:4], 1'b1);

    assign sum[0]   = p[0];
    assign sum[1]   = p[1] ^ c1;
    assign sum[2]   = p[2] ^ c2;
    assign sum[3]   = p[3] ^ c3;
    assign sum[7:4] = c4 ? hi_sum1 : hi_sum0;

endmodule

module ling8_stream_acc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_wraps,
    output logic             out_sat
);

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [7:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wr;
    logic             sticky;

    logic             accept;
    logic [7:0]       acc_op;
    logic [7:0]       sum_n;
    logic             wrap_n;
    logic             cnt_hold;
    logic             wr_hold;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] wr_nx;
    logic             sat_nx;

    // A free output slot, or one being popped this cycle, lets a beat in.
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // acc is already zero in EMPTY; the explicit zero operand just makes
    // the packet start independent of any stale accumulator value.
    assign acc_op = (state == EMPTY) ? 8'h00 : acc;

    P8_node_adder u_adder (
        .a   (acc_op),
        .b   (in_data),
        .sum (sum_n)
    );

    // The adder has no carry-out; a result smaller than the accumulator
    // operand means the 8-bit add wrapped.
    assign wrap_n = (sum_n < acc_op);

    // Saturating counter updates. A counter already at its maximum that
    // would step again holds, and that lost increment raises the sticky
    // saturation flag carried with the packet.
    always_comb begin
        cnt_hold = (cnt == CNT_MAX);
        wr_hold  = wrap_n & (wr == CNT_MAX);
        cnt_nx   = cnt_hold ? cnt : cnt + CNT_ONE;
        wr_nx    = (wrap_n & !wr_hold) ? wr + CNT_ONE : wr;
        sat_nx   = sticky | cnt_hold | wr_hold;
    end

    // Packet state machine and output register. A last-beat accept loads
    // the result and clears the accumulator; otherwise a pop drops
    // out_valid. Pop and load in the same cycle keep out_valid high, so
    // back-to-back packets flow without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            acc       <= '0;
            cnt       <= '0;
            wr        <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_wraps <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                if (in_last) begin
                    out_sum   <= sum_n;
                    out_count <= cnt_nx;
                    out_wraps <= wr_nx;
                    out_sat   <= sat_nx;
                    acc       <= '0;
                    cnt       <= '0;
                    wr        <= '0;
                    sticky    <= 1'b0;
                    state     <= EMPTY;
                end else begin
                    acc       <= sum_n;
                    cnt       <= cnt_nx;
                    wr        <= wr_nx;
                    sticky    <= sat_nx;
                    state     <= ACCUM;
                end
            end

            if (accept && in_last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ling8_stream_acc.sv
// ---------------------------------------------------------------------------
// tb_ling8_stream_acc
//
// Drives two instances of ling8_stream_acc (CNT_W = 8 and CNT_W = 2) with
// the same stream and compares both against a packet-level reference model:
// each packet's bytes are collected in a queue and, at the last beat, the
// expected sum, beat count and wrap count are derived from the plain
// arithmetic total of the bytes.
// ---------------------------------------------------------------------------
module tb_ling8_stream_acc;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready8;
    logic       out_valid8;
    logic [7:0] out_sum8;
    logic [7:0] out_count8;
    logic [7:0] out_wraps8;
    logic       out_sat8;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_sum2;
    logic [1:0] out_count2;
    logic [1:0] out_wraps2;
    logic       out_sat2;

    int tests_run;
    int tests_failed;

    // Reference model state
    int byte_q[$];
    int m_valid;
    int m_sum;
    int m_cnt8, m_wr8, m_sat8;
    int m_cnt2, m_wr2, m_sat2;

    ling8_stream_acc #(.CNT_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_sum   (out_sum8),
        .out_count (out_count8),
        .out_wraps (out_wraps8),
        .out_sat   (out_sat8)
    );

    ling8_stream_acc #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_sum   (out_sum2),
        .out_count (out_count2),
        .out_wraps (out_wraps2),
        .out_sat   (out_sat2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int satv(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        byte_q.delete();
        m_valid = 0;
        m_sum   = 0;
        m_cnt8  = 0; m_wr8 = 0; m_sat8 = 0;
        m_cnt2  = 0; m_wr2 = 0; m_sat2 = 0;
    endtask

    // Packet-level model of one clock edge.
    task automatic modelEdge(input logic v, input logic [7:0] d,
                             input logic l, input logic r);
        int ready;
        int total;
        int beats;
        int wraps;
        ready = (m_valid == 0 || r) ? 1 : 0;
        if (v && ready) begin
            byte_q.push_back(int'(d));
            if (l) begin
                total = 0;
                foreach (byte_q[i]) total += byte_q[i];
                beats  = byte_q.size();
                wraps  = total / 256;
                m_sum  = total % 256;
                m_cnt8 = satv(beats, 8);
                m_wr8  = satv(wraps, 8);
                m_sat8 = (beats > 255 || wraps > 255) ? 1 : 0;
                m_cnt2 = satv(beats, 2);
                m_wr2  = satv(wraps, 2);
                m_sat2 = (beats > 3 || wraps > 3) ? 1 : 0;
                m_valid = 1;
                byte_q.delete();
            end else if (r) begin
                m_valid = 0;
            end
        end else if (r) begin
            m_valid = 0;
        end
    endtask

    task automatic checkAll();
        checkOutput("out_valid8", out_valid8, m_valid);
        checkOutput("out_sum8",   out_sum8,   m_sum);
        checkOutput("out_count8", out_count8, m_cnt8);
        checkOutput("out_wraps8", out_wraps8, m_wr8);
        checkOutput("out_sat8",   out_sat8,   m_sat8);
        checkOutput("out_valid2", out_valid2, m_valid);
        checkOutput("out_sum2",   out_sum2,   m_sum);
        checkOutput("out_count2", out_count2, m_cnt2);
        checkOutput("out_wraps2", out_wraps2, m_wr2);
        checkOutput("out_sat2",   out_sat2,   m_sat2);
    endtask

    // One clock cycle: drive inputs (called 1 unit after a rising edge),
    // check in_ready before the edge, then check outputs after it.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic l, input logic r);
        int exp_ready;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        exp_ready = (m_valid == 0 || r) ? 1 : 0;
        checkOutput("in_ready8", in_ready8, exp_ready);
        checkOutput("in_ready2", in_ready2, exp_ready);
        @(posedge clk);
        modelEdge(v, d, l, r);
        #1;
        checkAll();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        modelReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        checkAll();
        checkOutput("reset_in_ready", in_ready8, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Simple packet
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b1);
        checkOutput("simple_sum",   out_sum8,   8'h60);
        checkOutput("simple_count", out_count8, 3);

        // Wrap-around packet
        applyStimulus(1'b1, 8'hF0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        checkOutput("wrap_sum",   out_sum8,   8'h0F);
        checkOutput("wrap_wraps", out_wraps8, 2);

        // Backpressure: pending result blocks the input for 5 cycles
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
            checkOutput("bp_sum_stable", out_sum8, 8'h0F);
        end
        // Pop and accept a new single-beat packet in the same cycle
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b1);
        checkOutput("bp_reload_valid", out_valid8, 1);
        checkOutput("bp_reload_sum",   out_sum8,   8'h11);

        // Back-to-back single-beat packets
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b1);
        checkOutput("b2b_sum1", out_sum8, 8'h01);
        applyStimulus(1'b1, 8'h02, 1'b1, 1'b1);
        checkOutput("b2b_sum2", out_sum8, 8'h02);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1);
        checkOutput("b2b_sum3",   out_sum8,   8'h03);
        checkOutput("b2b_count3", out_count8, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Saturation on the narrow counters
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h01, (i == 4), 1'b1);
        end
        checkOutput("sat_count2", out_count2, 3);
        checkOutput("sat_flag2",  out_sat2,   1);
        checkOutput("sat_sum2",   out_sum2,   8'h05);
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b1);
        checkOutput("sat_clear2", out_sat2, 0);

        // Async reset in the middle of a packet
        applyStimulus(1'b1, 8'h40, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h41, 1'b0, 1'b1);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 8'h05, 1'b1, 1'b1);
        checkOutput("post_reset_sum",   out_sum8,   8'h05);
        checkOutput("post_reset_count", out_count8, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          8'($urandom_range(0, 255)),
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
